// File: rtl/m_pkg.sv
// Shared types and constants for the RV32M issue/writeback sequencer.
package m_pkg;

    // Major opcode of register-register ALU ops and funct7 of the M extension
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Operation codes understood by the execution unit; NONE keeps it idle
    typedef enum logic [3:0] {
        CON_NONE   = 4'b0000,
        CON_MUL    = 4'b0001,
        CON_MULH   = 4'b0010,
        CON_MULHU  = 4'b0011,
        CON_MULHSU = 4'b0100,
        CON_DIV    = 4'b1000,
        CON_DIVU   = 4'b1001,
        CON_REM    = 4'b1010,
        CON_REMU   = 4'b1011
    } mul_con_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } m_issue_state_e;

endpackage

// File: rtl/m_decode.sv
// Combinational RV32M decoder: recognises M instructions and maps funct3 to
// the execution unit operation code.
module m_decode
    import m_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_m,
    output logic [3:0]  o_mul_con,
    output logic [4:0]  o_rd
);

    mul_con_e w_con;
    logic     w_unused;

    // Source register fields are not needed: operands arrive already forwarded
    assign w_unused = ^i_instr[24:15];

    // funct3 to operation code translation
    always_comb begin
        w_con = CON_NONE;
        case (i_instr[14:12])
            3'b000:  w_con = CON_MUL;
            3'b001:  w_con = CON_MULH;
            3'b010:  w_con = CON_MULHSU;
            3'b011:  w_con = CON_MULHU;
            3'b100:  w_con = CON_DIV;
            3'b101:  w_con = CON_DIVU;
            3'b110:  w_con = CON_REM;
            3'b111:  w_con = CON_REMU;
            default: w_con = CON_NONE;
        endcase
    end

    assign o_is_m    = (i_instr[6:0] == OPC_OP) && (i_instr[31:25] == F7_MULDIV);
    assign o_mul_con = o_is_m ? w_con : CON_NONE;
    assign o_rd      = i_instr[11:7];

endmodule

// File: rtl/m_issue.sv
// Issue/writeback sequencer in front of the M-extension execution unit.
// Holds one operation at a time, stalls the pipeline while it runs, and
// hands the result (or a timeout error) to writeback with ready/valid.
module m_issue
    import m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_mu_operand_a,
    output logic [31:0] o_mu_operand_b,
    output logic [3:0]  o_mu_con,
    output logic        o_mu_flush,
    input  logic [31:0] i_mu_result,
    input  logic        i_mu_done,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_wb_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    m_issue_state_e r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_op_a;
    logic [31:0]    r_op_b;
    logic [3:0]     r_mu_con;
    logic           r_mu_flush;
    logic           r_wb_valid;
    logic [4:0]     r_wb_rd;
    logic [31:0]    r_wb_data;
    logic           r_wb_err;

    logic           w_is_m;
    logic [3:0]     w_mul_con;
    logic [4:0]     w_rd;
    logic           w_accept;

    m_decode u_decode (
        .i_instr   (i_instr),
        .o_is_m    (w_is_m),
        .o_mul_con (w_mul_con),
        .o_rd      (w_rd)
    );

    assign w_accept = i_instr_valid && w_is_m && !i_flush;

    // The stall must reach upstream in the acceptance cycle, so it is not registered
    assign o_stall = (r_state != ST_IDLE) || (i_instr_valid && w_is_m);

    // Sequencer FSM with all unit-facing and writeback outputs registered
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_mu_con   <= CON_NONE;
            r_mu_flush <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_wb_err   <= 1'b0;
        end else if (i_flush && (r_state != ST_IDLE)) begin
            // Redirect cancels the in-flight operation; no writeback follows
            r_state    <= ST_IDLE;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_mu_con   <= CON_NONE;
            r_mu_flush <= 1'b1;
            r_wb_valid <= 1'b0;
        end else begin
            r_mu_flush <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_ARM;
                        r_op_a   <= i_rs1_data;
                        r_op_b   <= i_rs2_data;
                        r_mu_con <= w_mul_con;
                        r_wb_rd  <= w_rd;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    // done may still be asserted from the previous operation
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (i_mu_done) begin
                        r_wb_data  <= i_mu_result;
                        r_wb_err   <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_mu_con   <= CON_NONE;
                        r_state    <= ST_WB;
                    end else if (r_cnt == CNT_LAST) begin
                        r_wb_data  <= 32'd0;
                        r_wb_err   <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_mu_con   <= CON_NONE;
                        r_state    <= ST_WB;
                    end else begin
                        // Never passes CNT_LAST, so the counter cannot wrap
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    if (i_wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_op_a     <= 32'd0;
                        r_op_b     <= 32'd0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state    <= ST_WB;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mu_con   <= CON_NONE;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_mu_operand_a = r_op_a;
    assign o_mu_operand_b = r_op_b;
    assign o_mu_con       = r_mu_con;
    assign o_mu_flush     = r_mu_flush;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_wb_err       = r_wb_err;

endmodule

// File: tb/tb_m_issue.sv
// Self-checking bench for m_issue: behavioural execution-unit model plus an
// arithmetic reference for RV32M results and handshake timing.
module tb_m_issue;

    localparam int TO    = 16;
    localparam int LIMIT = TO + 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  mu_con;
    logic        mu_flush;
    logic [31:0] mu_result;
    logic        mu_done;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    logic [3:0] con_tab [8] = '{4'h1, 4'h2, 4'h4, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};

    always #5 clk = ~clk;

    m_issue #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(instr_valid), .i_instr(instr),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_flush(flush), .o_stall(stall),
        .o_mu_operand_a(op_a), .o_mu_operand_b(op_b), .o_mu_con(mu_con),
        .o_mu_flush(mu_flush), .i_mu_result(mu_result), .i_mu_done(mu_done),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_wb_err(wb_err)
    );

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Execution unit model: result by operation code, done after u_lat EXEC cycles
    function automatic logic [31:0] unit_calc(logic [3:0] con, logic [31:0] a, logic [31:0] b);
        for (int i = 0; i < 8; i++) if (con_tab[i] == con) return ref_result(3'(i), a, b);
        return 32'hDEADBEEF;
    endfunction

    int ucnt = 0;
    int u_lat = 0;
    bit u_stuck = 1'b0;
    bit u_stale = 1'b0;

    // Cycles since the unit was given a non-idle operation code
    always @(posedge clk) begin
        if (mu_con == 4'd0) ucnt <= 0;
        else ucnt <= ucnt + 1;
    end

    // Unit done/result outputs (combinational, as in the real unit)
    always_comb begin
        mu_done = 1'b0;
        if (mu_con != 4'd0) begin
            if (ucnt == 0) mu_done = u_stale;
            else mu_done = !u_stuck && (ucnt >= u_lat + 1);
        end
        mu_result = unit_calc(mu_con, op_a, op_b);
    end

    function automatic logic [31:0] enc(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        logic [9:0] rsf;
        rsf = 10'($urandom);
        return {f7, rsf, f3, rd, opc};
    endfunction

    // Issue one M instruction and observe it through writeback; comparisons are done by callers
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input bit stuck, input bit stale,
                         input int rdy_delay, output int wb_lat, output logic [31:0] d,
                         output logic [4:0] r, output logic e, output logic [3:0] ok);
        int n; int phase; int held;
        bit ok_stall, ok_con, ok_hold, ok_idle;
        ok_stall = 1'b1; ok_con = 1'b1; ok_hold = 1'b1; ok_idle = 1'b0;
        wb_lat = -1; d = 32'd0; r = 5'd0; e = 1'b0;
        u_lat = lat; u_stuck = stuck; u_stale = stale;
        @(posedge clk); #1;
        instr_valid = 1'b1; instr = enc(7'b0000001, f3, rd, 7'b0110011);
        rs1 = a; rs2 = b; wb_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        if (stall !== 1'b1) ok_stall = 1'b0;
        n = 0; phase = 0; held = 0;
        while (n < LIMIT && phase < 4) begin
            @(posedge clk); #1; n++;
            instr_valid = 1'b0; instr = $urandom; rs1 = $urandom; rs2 = $urandom;
            wb_ready = (phase == 2);
            @(negedge clk);
            case (phase)
                0: if (wb_valid === 1'b1) begin
                       wb_lat = n; d = wb_data; r = wb_rd; e = wb_err;
                       if (mu_con !== 4'd0 || stall !== 1'b1) ok_hold = 1'b0;
                       held = 1; phase = (held >= rdy_delay) ? 2 : 1;
                   end else begin
                       if (stall !== 1'b1) ok_stall = 1'b0;
                       if (mu_con !== con_tab[f3] || op_a !== a || op_b !== b) ok_con = 1'b0;
                   end
                1, 2: begin
                    if (wb_valid !== 1'b1 || wb_data !== d || wb_rd !== r || wb_err !== e
                        || stall !== 1'b1 || mu_con !== 4'd0) ok_hold = 1'b0;
                    held++;
                    if (phase == 2) phase = 3;
                    else if (held >= rdy_delay) phase = 2;
                end
                default: begin
                    ok_idle = (stall === 1'b0) && (wb_valid === 1'b0) && (mu_con === 4'd0)
                              && (op_a === 32'd0) && (op_b === 32'd0);
                    phase = 4;
                end
            endcase
        end
        wb_ready = 1'b0;
        ok = {ok_stall, ok_con, ok_hold, ok_idle};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        flush = 1'b0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (mu_con !== 4'd0) begin bad++; $display("FAIL reset_con got=%h want=0", mu_con); end
        total++; if (op_a !== 32'd0 || op_b !== 32'd0) begin bad++; $display("FAIL reset_ops got=%h/%h want=0", op_a, op_b); end
        total++; if (mu_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", mu_flush); end
        total++; if (wb_valid !== 1'b0 || wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b%b want=00", wb_valid, wb_err); end
        total++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL reset_wbdata got=%h/%h want=0", wb_rd, wb_data); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_directed(input string nm, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input int lat,
                                 input bit stuck, input bit stale, input int rdy,
                                 input int exp_lat, input logic [31:0] exp_d, input logic exp_e);
        int l; logic [31:0] d; logic [4:0] r; logic e; logic [3:0] ok;
        do_op(f3, a, b, rd, lat, stuck, stale, rdy, l, d, r, e, ok);
        total++; if (l !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, l, exp_lat); end
        total++; if (d !== exp_d) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, d, exp_d); end
        total++; if (r !== rd || e !== exp_e) begin bad++; $display("FAIL %s_rd_err got=%0d/%b want=%0d/%b", nm, r, e, rd, exp_e); end
        total++; if (ok !== 4'b1111) begin bad++; $display("FAIL %s_stall_con_hold_idle got=%b want=1111", nm, ok); end
    endtask

    task automatic test_flush_exec;
        u_lat = 20; u_stuck = 1'b0; u_stale = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b1; instr = enc(7'b0000001, 3'b100, 5'd9, 7'b0110011);
        rs1 = 32'd1000; rs2 = 32'd7;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1; instr_valid = 1'b0;
            if (n == 5) flush = 1'b1;
        end
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        total++; if (mu_flush !== 1'b1) begin bad++; $display("FAIL flush_pulse got=%b want=1", mu_flush); end
        total++; if (mu_con !== 4'd0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL flush_idle got con=%h stall=%b wbv=%b want 0/0/0", mu_con, stall, wb_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mu_flush !== 1'b0) begin bad++; $display("FAIL flush_onecycle got=%b want=0", mu_flush); end
        begin
            bit seen = 1'b0;
            repeat (TO + 8) begin @(negedge clk); if (wb_valid !== 1'b0) seen = 1'b1; end
            total++; if (seen) begin bad++; $display("FAIL flush_no_wb got=1 want=0"); end
        end
    endtask

    task automatic test_flush_wb;
        u_lat = 0; u_stuck = 1'b0; u_stale = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b1; instr = enc(7'b0000001, 3'b000, 5'd3, 7'b0110011);
        rs1 = 32'd6; rs2 = 32'd7;
        for (int n = 1; n <= 3; n++) begin @(posedge clk); #1; instr_valid = 1'b0; end
        @(negedge clk);
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'd42) begin bad++; $display("FAIL flushwb_pre got=%b/%h want=1/2a", wb_valid, wb_data); end
        @(posedge clk); #1; flush = 1'b1; wb_ready = 1'b1;
        @(posedge clk); #1; flush = 1'b0; wb_ready = 1'b0;
        @(negedge clk);
        total++; if (mu_flush !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL flushwb_wins got flush=%b wbv=%b stall=%b want 1/0/0", mu_flush, wb_valid, stall); end
    endtask

    task automatic test_flush_idle;
        @(posedge clk); #1;
        instr_valid = 1'b1; flush = 1'b1; instr = enc(7'b0000001, 3'b000, 5'd4, 7'b0110011);
        @(posedge clk); #1; instr_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (mu_con !== 4'd0 || stall !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept got con=%h stall=%b want 0/0", mu_con, stall); end
    endtask

    task automatic test_non_m;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            instr_valid = 1'b1;
            if (i == 0) instr = enc(7'b0000000, 3'b000, 5'd1, 7'b0110011);
            else if (i[0]) instr = enc(7'($urandom_range(2, 127)), 3'($urandom), 5'($urandom), 7'b0110011);
            else instr = enc(7'b0000001, 3'($urandom), 5'($urandom), 7'b0010011);
            @(negedge clk);
            total++; if (stall !== 1'b0 || mu_con !== 4'd0) begin
                bad++; $display("FAIL non_m_%0d got stall=%b con=%h want 0/0", i, stall, mu_con); end
        end
        @(posedge clk); #1; instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        u_lat = 20; u_stuck = 1'b0; u_stale = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b1; instr = enc(7'b0000001, 3'b001, 5'd7, 7'b0110011); rs1 = 32'd5; rs2 = 32'd9;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (stall !== 1'b0 || mu_con !== 4'd0 || op_a !== 32'd0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid got stall=%b con=%h a=%h wbv=%b want all 0", stall, mu_con, op_a, wb_valid); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_random;
        logic [31:0] corner [5] = '{32'd0, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF};
        for (int i = 0; i < 30; i++) begin
            logic [2:0] f3; logic [31:0] a, b; logic [4:0] rd; int lat, el, l;
            logic [31:0] d, ed; logic [4:0] r; logic e, ee; logic [3:0] ok;
            f3 = 3'($urandom); rd = 5'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 5);
            el = (lat >= TO) ? TO + 2 : lat + 3;
            ed = (lat >= TO) ? 32'd0 : ref_result(f3, a, b);
            ee = (lat >= TO);
            do_op(f3, a, b, rd, lat, 1'b0, 1'($urandom), $urandom_range(1, 3), l, d, r, e, ok);
            total++; if (l !== el || d !== ed || r !== rd || e !== ee || ok !== 4'b1111) begin
                bad++; $display("FAIL random_%0d f3=%0d a=%h b=%h got lat=%0d d=%h rd=%0d err=%b ok=%b want lat=%0d d=%h rd=%0d err=%b ok=1111",
                                i, f3, a, b, l, d, r, e, ok, el, ed, rd, ee);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 4, 1'b0, 1'b0, 1, 7, 32'hFFFFFFEB, 1'b0);
        test_directed("divu_zero", 3'b101, 32'd100, 32'd0, 5'd2, 0, 1'b0, 1'b1, 1, 3, 32'hFFFFFFFF, 1'b0);
        test_directed("remu_hold", 3'b111, 32'd23, 32'd5, 5'd11, 2, 1'b0, 1'b0, 10, 5, 32'd3, 1'b0);
        test_directed("timeout", 3'b100, 32'd50, 32'd5, 5'd8, 0, 1'b1, 1'b0, 1, TO + 2, 32'd0, 1'b1);
        test_directed("done_last", 3'b000, 32'd3, 32'd4, 5'd0, TO - 1, 1'b0, 1'b0, 1, TO + 2, 32'd12, 1'b0);
        test_directed("done_late", 3'b000, 32'd3, 32'd4, 5'd1, TO, 1'b0, 1'b0, 2, TO + 2, 32'd0, 1'b1);
        test_flush_exec();
        test_flush_wb();
        test_flush_idle();
        test_non_m();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_issue.md
# m_issue

Issue/writeback sequencer sitting directly upstream of the M-extension execution unit. Decodes RV32M instructions from the core's execute stage, latches operands and destination register, and drives a stable operation code to the unit for the whole operation. Stalls the pipeline while the operation runs, supports flush on branch, and presents the result to the register-file writeback port with a ready/valid handshake.

## Interface
- TIMEOUT_CYCLES, 128: maximum EXEC cycles before the operation is aborted with an error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  `instr`, `rs1_data` and `rs2_data` are valid this cycle.
- instr  in  32  raw instruction word.
- rs1_data  in  32  forwarded rs1 value.
- rs2_data  in  32  forwarded rs2 value.
- flush  in  1  branch/redirect; cancels any in-flight operation.
- stall  out  1  hold upstream pipeline.
- mu_operand_a  out  32  to execution unit operand_a.
- mu_operand_b  out  32  to execution unit operand_b.
- mu_con  out  4  to execution unit mul_con; 0 means idle.
- mu_flush  out  1  to execution unit branch_output.
- mu_result  in  32  from execution unit out_result.
- mu_done  in  1  from execution unit out_done.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  writeback port accepts.
- wb_rd  out  5  destination register.
- wb_data  out  32  result.
- wb_err  out  1  result produced by timeout, not by the unit.

## Operation
- M instruction: opcode 7'b0110011 and funct7 7'b0000001. Any other instruction is ignored and never asserts stall.
- funct3 to mu_con: 000→0001 MUL, 001→0010 MULH, 010→0100 MULHSU, 011→0011 MULHU, 100→1000 DIV, 101→1001 DIVU, 110→1010 REM, 111→1011 REMU.
- FSM states IDLE, ARM, EXEC, WB.
- IDLE: if instr_valid and M instruction and no flush, latch rs1/rs2/rd/con, clear the timeout counter, go to ARM.
- ARM: drive the latched mu_con and operands. mu_done is ignored because it may be stale from the previous operation. Go to EXEC.
- EXEC: keep driving mu_con. On mu_done, capture mu_result into wb_data with wb_err=0 and go to WB. Otherwise increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without mu_done, set wb_data=0, wb_err=1 and go to WB.
- WB: mu_con=0, wb_valid=1. wb_valid, wb_data, wb_rd and wb_err stay stable until wb_ready is sampled high, then go to IDLE.
- stall = (state≠IDLE) or (state==IDLE and instr_valid and M instruction).
- flush in ARM, EXEC or WB: go to IDLE next cycle and raise mu_flush for exactly that one cycle. mu_con is 0 from that cycle on, and no writeback occurs. flush in IDLE blocks acceptance that cycle.
- rd=0 executes normally and writes back wb_rd=0; the register file discards it.
- mu_operand_a/b hold the latched values in every non-IDLE state and are 0 in IDLE.

## Timing
- Reset: state IDLE; stall, mu_con, mu_operand_a/b, mu_flush, wb_valid, wb_rd, wb_data, wb_err all 0; counter 0.
- Reset mid-operation discards the operation; the outputs take their reset values the next cycle.
- Acceptance in cycle k: ARM in k+1, EXEC from k+2. The first mu_done sampled in cycle m≥k+2 gives wb_valid in cycle m+1.
- Minimum latency from accept to wb_valid is 3 cycles. This applies to zero-operand and divide-by-zero cases, where the unit's done output is combinational.
- Timeout: wb_valid is asserted at cycle k+2+TIMEOUT_CYCLES.
- A new instruction is accepted only in IDLE, so there is at most one in flight; back-to-back M instructions are separated by at least one IDLE cycle.
- flush and wb_ready both high in WB: flush wins, and the handshake is not counted as a transfer.

## Structure
- Package m_pkg: mul_con_e enum (the eight codes plus NONE=0), the OPC_OP and F7_MULDIV constants, and the m_issue_state_e enum.
- Sub-module m_decode: combinational; instr → is_m, mul_con, rd. Instantiated once.
- The counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → stall for the duration; wb_valid with wb_rd=5, wb_data=0xFFFFFFEB, wb_err=0.
- DIVU with rs1=100, rs2=0 → wb_data=0xFFFFFFFF at cycle k+3.
- DIV with rs1=1000, rs2=7, flush in the 4th EXEC cycle → one-cycle mu_flush pulse, mu_con=0, no wb_valid, stall deasserted the next cycle.
- REMU with rs1=23, rs2=5, wb_ready held low 10 cycles after wb_valid → wb_data=3 held stable; IDLE one cycle after wb_ready rises.
- Unit model with mu_done stuck low, TIMEOUT_CYCLES=16 → wb_valid at k+18 with wb_err=1, wb_data=0.
- ADD instruction (funct7=0) with instr_valid high → stall=0, mu_con remains 0.
